// File: rtl/rf_dump_ctrl_if.sv
// Bundle between the register-file sequencer and its surroundings: start/mode
// control, the register-file read/write ports and the dump output stream.
interface rf_dump_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic              mode;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rf_read_reg;
  logic [DATA_W-1:0] rf_read_data;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_we;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    input  start, mode, rf_read_data, out_ready,
    output busy, done, rf_read_reg, rf_write_reg, rf_write_data, rf_we,
           out_valid, out_addr, out_data
  );

  modport slave (
    output start, mode, rf_read_data, out_ready,
    input  busy, done, rf_read_reg, rf_write_reg, rf_write_data, rf_we,
           out_valid, out_addr, out_data
  );
endinterface

// File: rtl/rf_dump_ctrl.sv
// Debug sequencer that sweeps the core register file: either streams every
// register out over valid/ready, or writes zero into every register.
module rf_dump_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  rf_dump_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_LATCH = 3'd2,
    S_OUT   = 3'd3,
    S_CLR   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] ONE_IDX   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ZERO_IDX  = '0;
  localparam logic [DATA_W-1:0] ZERO_DATA = '0;

  state_t            state_r;
  logic [ADDR_W-1:0] idx_r;

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= S_IDLE;
      idx_r             <= ZERO_IDX;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.rf_read_reg   <= ZERO_IDX;
      bus.rf_write_reg  <= ZERO_IDX;
      bus.rf_write_data <= ZERO_DATA;
      bus.rf_we         <= 1'b0;
      bus.out_valid     <= 1'b0;
      bus.out_addr      <= ZERO_IDX;
      bus.out_data      <= ZERO_DATA;
    end else begin
      case (state_r)
        S_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            idx_r    <= ZERO_IDX;
            bus.busy <= 1'b1;
            if (bus.mode) begin
              state_r           <= S_CLR;
              bus.rf_we         <= 1'b1;
              bus.rf_write_reg  <= ZERO_IDX;
              bus.rf_write_data <= ZERO_DATA;
            end else begin
              state_r         <= S_ISSUE;
              bus.rf_read_reg <= ZERO_IDX;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end

        // Register file latches rf_read_reg at the end of this cycle.
        S_ISSUE: begin
          state_r <= S_LATCH;
        end

        S_LATCH: begin
          bus.out_data  <= bus.rf_read_data;
          bus.out_addr  <= idx_r;
          bus.out_valid <= 1'b1;
          state_r       <= S_OUT;
        end

        // Only this state stalls; the next read is not issued until accepted.
        S_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (idx_r == LAST_IDX) begin
              state_r  <= S_DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              idx_r           <= idx_r + ONE_IDX;
              bus.rf_read_reg <= idx_r + ONE_IDX;
              state_r         <= S_ISSUE;
            end
          end else begin
            state_r <= S_OUT;
          end
        end

        S_CLR: begin
          if (idx_r == LAST_IDX) begin
            bus.rf_we <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            state_r   <= S_DONE;
          end else begin
            idx_r            <= idx_r + ONE_IDX;
            bus.rf_write_reg <= idx_r + ONE_IDX;
            state_r          <= S_CLR;
          end
        end

        S_DONE: begin
          bus.done <= 1'b0;
          state_r  <= S_IDLE;
        end

        default: begin
          state_r       <= S_IDLE;
          bus.busy      <= 1'b0;
          bus.done      <= 1'b0;
          bus.rf_we     <= 1'b0;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// Directed bench for rf_dump_ctrl with a behavioural register file that has
// a one-cycle registered read port and a synchronous write port.
module tb_rf_dump_ctrl;

  logic clk;
  logic rst;
  logic load_pat;
  int   errors;
  int   checks;

  logic [31:0] mem     [32];
  logic [31:0] exp_mem [32];

  rf_dump_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  rf_dump_ctrl #(.ADDR_W(5), .DATA_W(32), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: pattern preload, write port, registered read.
  always @(posedge clk) begin
    if (load_pat) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (bus.rf_we) begin
      mem[bus.rf_write_reg] <= bus.rf_write_data;
    end
    bus.rf_read_data <= mem[bus.rf_read_reg];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload();
    @(negedge clk);
    load_pat = 1'b1;
    @(negedge clk);
    load_pat = 1'b0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'hA500_0000 | 32'(i);
  endtask

  task automatic do_dump(input bit stall7, input bit poke);
    int cyc, beat, exp_cyc, stall_left, done_cnt, post;
    bit seen, extra_seen;
    cyc = 0; beat = 0; exp_cyc = 3; stall_left = 0; done_cnt = 0; post = -1;
    seen = 1'b0; extra_seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.out_ready = 1'b1;
    while (cyc < 600 && post != 0) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      if (post > 0) post--;
      if (bus.done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          chk("done_after_last", 32'(beat), 32'd32);
          post = 8;
          if (poke) bus.start = 1'b1;
        end
      end
      if (bus.out_valid) begin
        if (beat >= 32) begin
          if (!extra_seen) chk("extra_beat", 32'(bus.out_valid), 32'd0);
          extra_seen = 1'b1;
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("beat_addr", 32'(bus.out_addr), 32'(beat));
            chk("beat_data", bus.out_data, exp_mem[beat]);
            chk("beat_time", 32'(cyc), 32'(exp_cyc));
            chk("beat_busy", 32'(bus.busy), 32'd1);
            if (stall7 && beat == 7) stall_left = 5;
            if (poke && beat == 4) begin
              bus.start = 1'b1;
              bus.mode  = 1'b1;
            end
          end else begin
            chk("hold_addr", 32'(bus.out_addr), 32'(beat));
            chk("hold_data", bus.out_data, exp_mem[beat]);
            chk("hold_rd_reg", 32'(bus.rf_read_reg), 32'(beat));
          end
          if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
          end else begin
            bus.out_ready = 1'b1;
            beat++;
            seen = 1'b0;
            exp_cyc = cyc + 3;
          end
        end
      end else begin
        bus.out_ready = 1'b1;
      end
    end
    chk("dump_finished", 32'(post == 0), 32'd1);
    chk("dump_beats", 32'(beat), 32'd32);
    chk("dump_done_cnt", 32'(done_cnt), 32'd1);
    chk("dump_busy_end", 32'(bus.busy), 32'd0);
    chk("dump_we_never", 32'(bus.rf_we), 32'd0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.mode = 1'b0;
      if (c <= 32) begin
        chk("clr_we", 32'(bus.rf_we), 32'd1);
        chk("clr_wreg", 32'(bus.rf_write_reg), 32'(c - 1));
        chk("clr_wdata", bus.rf_write_data, 32'd0);
        chk("clr_busy", 32'(bus.busy), 32'd1);
        chk("clr_nodone", 32'(bus.done), 32'd0);
      end else begin
        chk("clr_we_off", 32'(bus.rf_we), 32'd0);
        chk("clr_done", 32'(bus.done), 32'(c == 33));
        chk("clr_busy_off", 32'(bus.busy), 32'd0);
      end
    end
    for (int i = 0; i < 32; i++) begin
      chk("clr_mem", mem[i], 32'd0);
      exp_mem[i] = 32'd0;
    end
  endtask

  task automatic do_clear_abort(input int k);
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b1;
    for (int c = 1; c <= k + 1; c++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.mode = 1'b0;
    end
    chk("abort_wreg", 32'(bus.rf_write_reg), 32'(k));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we", 32'(bus.rf_we), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.done || bus.rf_we) done_seen++;
    end
    chk("abort_quiet", 32'(done_seen), 32'd0);
    for (int i = 0; i < 32; i++) begin
      if (i <= k) exp_mem[i] = 32'd0;
      chk("abort_mem", mem[i], exp_mem[i]);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; load_pat = 1'b0;
    bus.start = 1'b1; bus.mode = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'd0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_we", 32'(bus.rf_we), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_rd_reg", 32'(bus.rf_read_reg), 32'd0);
    chk("rst_wr_reg", 32'(bus.rf_write_reg), 32'd0);
    chk("rst_wr_data", bus.rf_write_data, 32'd0);
    chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    rst = 1'b0; bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_we", 32'(bus.rf_we), 32'd0);
    end

    preload();
    do_dump(1'b0, 1'b0);
    do_dump(1'b1, 1'b1);
    do_clear();
    do_dump(1'b0, 1'b0);
    preload();
    do_clear_abort(10);
    do_dump(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
